// File: rtl/light_phase_sequencer_pkg.sv
// Shared traffic definitions: mode codes, phase states, lamp patterns.
// Lamp triples are ordered {red,yellow,green}.
package traffic_pkg;

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [3:0] {
    ST_ALLRED      = 4'd0,
    ST_NS_GREEN    = 4'd1,
    ST_NS_YELLOW   = 4'd2,
    ST_EW_GREEN    = 4'd3,
    ST_EW_YELLOW   = 4'd4,
    ST_WALK        = 4'd5,
    ST_NIGHT_FLASH = 4'd6,
    ST_EMG_HOLD    = 4'd7
  } state_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  function automatic lamps_t lamp_decode(
    input state_t s,
    input logic   flash
  );
    lamps_t l;
    l = '{ns: LAMP_R, ew: LAMP_R, walk: 1'b0};
    unique case (s)
      ST_NS_GREEN:    l.ns = LAMP_G;
      ST_NS_YELLOW:   l.ns = LAMP_Y;
      ST_EW_GREEN:    l.ew = LAMP_G;
      ST_EW_YELLOW:   l.ew = LAMP_Y;
      ST_WALK:        l.walk = 1'b1;
      ST_NIGHT_FLASH: begin
        l.ns = flash ? LAMP_Y : LAMP_OFF;
        l.ew = flash ? LAMP_R : LAMP_OFF;
      end
      default:        l = '{ns: LAMP_R, ew: LAMP_R, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/light_phase_sequencer_phase_timer.sv
// Loadable down-counter that times each phase.
// done pulses on the tick that consumes the final count.
module phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (load)
      count <= load_val;
    else if (tick && count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0) & tick;

endmodule

// File: rtl/light_phase_sequencer.sv
// Intersection phase sequencer: timed day cycle, night flash,
// pedestrian walk and emergency hold with all-red clearance.
module light_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10,
  parameter int FLASH_TICKS  = 1,
  parameter int CNT_W        = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [3:0] phase
);

  state_t           state, state_nxt;
  logic             dir, dir_nxt;
  logic             flash, flash_nxt;
  logic             ped, ped_nxt;
  logic             reload;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             done;
  lamps_t           lamps_nxt;

  function automatic logic [CNT_W-1:0] dur(input state_t s);
    logic [CNT_W-1:0] v;
    unique case (s)
      ST_NS_GREEN, ST_EW_GREEN:   v = CNT_W'(GREEN_TICKS - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: v = CNT_W'(YELLOW_TICKS - 1);
      ST_WALK:                    v = CNT_W'(WALK_TICKS - 1);
      ST_NIGHT_FLASH:             v = CNT_W'(FLASH_TICKS - 1);
      ST_ALLRED:                  v = CNT_W'(ALLRED_TICKS - 1);
      default:                    v = '0;
    endcase
    return v;
  endfunction

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .done     (done)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    flash_nxt = flash;
    reload    = 1'b0;
    unique case (state)
      ST_NS_GREEN:
        if (mode == MODE_EMG || done) state_nxt = ST_NS_YELLOW;
      ST_NS_YELLOW:
        if (done) begin
          state_nxt = ST_ALLRED;
          dir_nxt   = 1'b1;
        end
      ST_EW_GREEN:
        if (mode == MODE_EMG || done) state_nxt = ST_EW_YELLOW;
      ST_EW_YELLOW:
        if (done) begin
          state_nxt = ST_ALLRED;
          dir_nxt   = 1'b0;
        end
      ST_ALLRED:
        if (done) begin
          if (mode == MODE_EMG)        state_nxt = ST_EMG_HOLD;
          else if (ped)                state_nxt = ST_WALK;
          else if (mode == MODE_NIGHT) state_nxt = ST_NIGHT_FLASH;
          else if (dir)                state_nxt = ST_EW_GREEN;
          else                         state_nxt = ST_NS_GREEN;
        end
      ST_WALK:
        if (mode == MODE_EMG || done) state_nxt = ST_ALLRED;
      ST_NIGHT_FLASH:
        if (mode != MODE_NIGHT) begin
          state_nxt = ST_ALLRED;
          dir_nxt   = 1'b0;
          flash_nxt = 1'b0;
        end else if (done) begin
          flash_nxt = ~flash;
          reload    = 1'b1;
        end
      ST_EMG_HOLD:
        if (mode != MODE_EMG) state_nxt = ST_ALLRED;
      default:
        state_nxt = ST_ALLRED;
    endcase

    // Entering WALK consumes the request even if one arrives this edge.
    ped_nxt = ped;
    if (state_nxt == ST_WALK && state != ST_WALK)
      ped_nxt = 1'b0;
    else if (mode == MODE_PED)
      ped_nxt = 1'b1;

    load      = !rst || (state_nxt != state) || reload;
    load_val  = !rst ? CNT_W'(ALLRED_TICKS - 1) : dur(state_nxt);
    lamps_nxt = lamp_decode(state_nxt, flash_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_ALLRED;
      dir      <= 1'b0;
      flash    <= 1'b0;
      ped      <= 1'b0;
      ns_light <= LAMP_R;
      ew_light <= LAMP_R;
      walk     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      flash    <= flash_nxt;
      ped      <= ped_nxt;
      ns_light <= lamps_nxt.ns;
      ew_light <= lamps_nxt.ew;
      walk     <= lamps_nxt.walk;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Bench for light_phase_sequencer: vector table, directed corner
// sequences and random traffic against a remaining-ticks model.
module tb_light_phase_sequencer;
  import traffic_pkg::*;

  localparam int G  = 3;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int WK = 2;
  localparam int FL = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] ns_light, ew_light;
  logic       walk;
  logic [3:0] phase;

  int n_cmp = 0;
  int n_bad = 0;

  light_phase_sequencer #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALLRED_TICKS (AR),
    .WALK_TICKS   (WK),
    .FLASH_TICKS  (FL),
    .CNT_W        (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mode     (mode),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Model: state plus the number of ticks still owed to it.
  state_t ms = ST_ALLRED;
  int     left = AR;
  bit     mdir, mped, mflash;
  logic [3:0] prev_phase = 4'd0;

  function automatic int dur(input state_t s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   return G;
      ST_NS_YELLOW, ST_EW_YELLOW: return Y;
      ST_WALK:                    return WK;
      ST_NIGHT_FLASH:             return FL;
      ST_ALLRED:                  return AR;
      default:                    return 1;
    endcase
  endfunction

  function automatic logic [2:0] m_ns(input state_t s, input bit f);
    case (s)
      ST_NS_GREEN:    return 3'b001;
      ST_NS_YELLOW:   return 3'b010;
      ST_NIGHT_FLASH: return f ? 3'b010 : 3'b000;
      default:        return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] m_ew(input state_t s, input bit f);
    case (s)
      ST_EW_GREEN:    return 3'b001;
      ST_EW_YELLOW:   return 3'b010;
      ST_NIGHT_FLASH: return f ? 3'b100 : 3'b000;
      default:        return 3'b100;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit t, input logic [1:0] m);
    state_t nx;
    bit     ex, refl;
    if (!r) begin
      ms = ST_ALLRED; left = AR; mdir = 0; mped = 0; mflash = 0;
      return;
    end
    ex = t && left == 1;
    nx = ms;
    refl = 0;
    case (ms)
      ST_NS_GREEN:  if (m == 2'd3 || ex) nx = ST_NS_YELLOW;
      ST_NS_YELLOW: if (ex) begin nx = ST_ALLRED; mdir = 1; end
      ST_EW_GREEN:  if (m == 2'd3 || ex) nx = ST_EW_YELLOW;
      ST_EW_YELLOW: if (ex) begin nx = ST_ALLRED; mdir = 0; end
      ST_ALLRED:
        if (ex) begin
          if (m == 2'd3)      nx = ST_EMG_HOLD;
          else if (mped)      nx = ST_WALK;
          else if (m == 2'd1) nx = ST_NIGHT_FLASH;
          else                nx = mdir ? ST_EW_GREEN : ST_NS_GREEN;
        end
      ST_WALK:      if (m == 2'd3 || ex) nx = ST_ALLRED;
      ST_NIGHT_FLASH:
        if (m != 2'd1) begin
          nx = ST_ALLRED; mdir = 0; mflash = 0;
        end else if (ex) begin
          mflash = !mflash; refl = 1;
        end
      ST_EMG_HOLD:  if (m != 2'd3) nx = ST_ALLRED;
      default:      nx = ST_ALLRED;
    endcase
    if (nx == ST_WALK && ms != ST_WALK) mped = 0;
    else if (m == 2'd2) mped = 1;
    if (nx != ms || refl) left = dur(nx);
    else if (t && left > 1) left--;
    ms = nx;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit t, input logic [1:0] m);
    @(negedge clk);
    rst = r; tick = t; mode = m;
    @(posedge clk);
    model_step(r, t, m);
    #1;
    chk("phase", int'(phase), int'(ms));
    chk("ns", int'(ns_light), int'(m_ns(ms, mflash)));
    chk("ew", int'(ew_light), int'(m_ew(ms, mflash)));
    chk("walk", int'(walk), int'(ms == ST_WALK));
    chk("two_green", int'(ns_light == 3'b001 && ew_light == 3'b001), 0);
    chk("green_adjacent",
        int'((prev_phase == 4'd1 && phase == 4'd3) ||
             (prev_phase == 4'd3 && phase == 4'd1)), 0);
    prev_phase = phase;
  endtask

  task automatic wait_phase(input state_t target, input string nm);
    for (int i = 0; i < 40; i++) begin
      if (phase == target) break;
      cycle(1, 1, 2'd0);
    end
    chk(nm, int'(phase), int'(target));
  endtask

  typedef struct {
    bit         r;
    bit         t;
    logic [1:0] m;
    state_t     ph;
    logic [2:0] ns;
    logic [2:0] ew;
    bit         wk;
  } vec_t;

  vec_t tv[15];

  initial begin
    tv[0]  = '{0, 1, 2'd0, ST_ALLRED,    3'b100, 3'b100, 0};
    tv[1]  = '{0, 1, 2'd0, ST_ALLRED,    3'b100, 3'b100, 0};
    tv[2]  = '{1, 1, 2'd0, ST_NS_GREEN,  3'b001, 3'b100, 0};
    tv[3]  = '{1, 1, 2'd0, ST_NS_GREEN,  3'b001, 3'b100, 0};
    tv[4]  = '{1, 1, 2'd0, ST_NS_GREEN,  3'b001, 3'b100, 0};
    tv[5]  = '{1, 1, 2'd0, ST_NS_YELLOW, 3'b010, 3'b100, 0};
    tv[6]  = '{1, 1, 2'd0, ST_NS_YELLOW, 3'b010, 3'b100, 0};
    tv[7]  = '{1, 1, 2'd0, ST_ALLRED,    3'b100, 3'b100, 0};
    tv[8]  = '{1, 1, 2'd0, ST_EW_GREEN,  3'b100, 3'b001, 0};
    tv[9]  = '{1, 1, 2'd0, ST_EW_GREEN,  3'b100, 3'b001, 0};
    tv[10] = '{1, 1, 2'd0, ST_EW_GREEN,  3'b100, 3'b001, 0};
    tv[11] = '{1, 1, 2'd0, ST_EW_YELLOW, 3'b100, 3'b010, 0};
    tv[12] = '{1, 1, 2'd0, ST_EW_YELLOW, 3'b100, 3'b010, 0};
    tv[13] = '{1, 1, 2'd0, ST_ALLRED,    3'b100, 3'b100, 0};
    tv[14] = '{1, 1, 2'd0, ST_NS_GREEN,  3'b001, 3'b100, 0};

    for (int i = 0; i < 15; i++) begin
      cycle(tv[i].r, tv[i].t, tv[i].m);
      chk("tbl_phase", int'(phase), int'(tv[i].ph));
      chk("tbl_ns", int'(ns_light), int'(tv[i].ns));
      chk("tbl_ew", int'(ew_light), int'(tv[i].ew));
      chk("tbl_walk", int'(walk), int'(tv[i].wk));
    end

    // Emergency preempts NS green in its 2nd cycle.
    for (int i = 0; i < 9; i++) begin
      cycle(1, 1, 2'd3);
      if (i == 0) chk("emg_to_yellow", int'(phase), int'(ST_NS_YELLOW));
      if (i == 2) chk("emg_allred", int'(phase), int'(ST_ALLRED));
      if (i == 8) chk("emg_hold", int'(phase), int'(ST_EMG_HOLD));
    end
    cycle(1, 1, 2'd0);
    chk("emg_exit", int'(phase), int'(ST_ALLRED));
    cycle(1, 1, 2'd0);
    chk("emg_ew_next", int'(phase), int'(ST_EW_GREEN));

    // Pedestrian pulse in EW green.
    cycle(1, 1, 2'd2);
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 1, 2'd0);
      if (i == 2) chk("ped_green_full", int'(phase), int'(ST_EW_YELLOW));
      if (i == 5) chk("ped_walk", int'(walk), 1);
      if (i == 8) chk("ped_ns_next", int'(phase), int'(ST_NS_GREEN));
    end

    // Night after a normal clearance.
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 1, 2'd1);
      if (i == 6) chk("night_enter", int'(phase), int'(ST_NIGHT_FLASH));
      if (i == 7) chk("night_flash_ns", int'(ns_light), int'(LAMP_Y));
      if (i == 8) chk("night_flash_off", int'(ns_light), int'(LAMP_OFF));
    end
    cycle(1, 1, 2'd0);
    chk("night_exit", int'(phase), int'(ST_ALLRED));
    cycle(1, 1, 2'd0);
    chk("night_ns_next", int'(phase), int'(ST_NS_GREEN));

    // Emergency aborts a walk.
    cycle(1, 1, 2'd2);
    wait_phase(ST_WALK, "reach_walk");
    cycle(1, 1, 2'd3);
    chk("walk_abort", int'(phase), int'(ST_ALLRED));
    chk("walk_abort_lamp", int'(walk), 0);
    cycle(1, 1, 2'd3);
    chk("walk_abort_emg", int'(phase), int'(ST_EMG_HOLD));

    // Tick gating and tick-independent preemption.
    wait_phase(ST_NS_GREEN, "reach_ns_green");
    for (int i = 0; i < 10; i++) cycle(1, 0, 2'd0);
    chk("tick_hold", int'(phase), int'(ST_NS_GREEN));
    cycle(1, 0, 2'd3);
    chk("preempt_no_tick", int'(phase), int'(ST_NS_YELLOW));

    // Reset during EW yellow discards the pedestrian request.
    wait_phase(ST_EW_GREEN, "reach_ew_green");
    cycle(1, 1, 2'd2);
    wait_phase(ST_EW_YELLOW, "reach_ew_yellow");
    cycle(0, 1, 2'd0);
    chk("rst_phase", int'(phase), int'(ST_ALLRED));
    chk("rst_ns", int'(ns_light), int'(LAMP_R));
    chk("rst_walk", int'(walk), 0);
    cycle(1, 1, 2'd0);
    chk("rst_no_walk", int'(phase), int'(ST_NS_GREEN));

    // Random traffic against the model.
    begin
      logic [1:0] m;
      bit t, r;
      m = 2'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
        t = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 99) != 0);
        cycle(r, t, m);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
